// File: rtl/tx_packet_arbiter.sv
// Shares the TX FIFO write port between the MCP sampler, CCD pixel stream and status
// replies: round-robin grant, then a header byte plus 1-4 payload bytes, LSB first.
//
// state | meaning
// IDLE  | no packet in flight; arbitrates pending requests and latches the winner
// HDR   | header byte pending, held while the FIFO reports full
// GAP   | post-write spacing of GAP_CYCLES so the full flag can catch up
// BYTE  | payload byte pending, held while the FIFO reports full

module tx_packet_arbiter #(
  parameter logic [3:0] HDR_TAG    = 4'hA,
  parameter int         GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [5:0]  len_m1,
  input  logic [95:0] data,
  output logic [2:0]  ack,
  output logic        busy,
  input  logic        tx_wfull,
  output logic        tx_winc,
  output logic [7:0]  tx_wdata,
  output logic [15:0] pkt_count
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_GAP, S_BYTE} state_t;

  localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES - 1);

  state_t      state, state_d;
  logic [1:0]  rr_last, rr_last_d;
  logic [1:0]  src, src_d;
  logic [1:0]  len, len_d;
  logic [1:0]  byte_idx, byte_idx_d;
  logic [31:0] payload, payload_d;
  logic [2:0]  gap_cnt, gap_cnt_d;
  logic        last_byte, last_byte_d;
  logic [2:0]  ack_d;
  logic        busy_d;
  logic        winc_d;
  logic [7:0]  wdata_d;
  logic [15:0] pkt_count_d;

  logic [1:0]  pri0, pri1, pri2, winner;
  logic [31:0] win_data;
  logic [1:0]  win_len;
  logic [7:0]  cur_byte;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Priority rotates so the requester after the last winner is considered first.
  always_comb begin
    pri0 = rr_next(rr_last);
    pri1 = rr_next(pri0);
    pri2 = rr_next(pri1);
    if (req[pri0])      winner = pri0;
    else if (req[pri1]) winner = pri1;
    else                winner = pri2;
  end

  always_comb begin
    case (winner)
      2'd0:    begin win_data = data[31:0];  win_len = len_m1[1:0]; end
      2'd1:    begin win_data = data[63:32]; win_len = len_m1[3:2]; end
      default: begin win_data = data[95:64]; win_len = len_m1[5:4]; end
    endcase
  end

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = payload[7:0];
      2'd1:    cur_byte = payload[15:8];
      2'd2:    cur_byte = payload[23:16];
      default: cur_byte = payload[31:24];
    endcase
  end

  always_comb begin
    state_d     = state;
    rr_last_d   = rr_last;
    src_d       = src;
    len_d       = len;
    byte_idx_d  = byte_idx;
    payload_d   = payload;
    gap_cnt_d   = gap_cnt;
    last_byte_d = last_byte;
    ack_d       = 3'b000;
    winc_d      = 1'b0;
    wdata_d     = tx_wdata;
    pkt_count_d = pkt_count;

    case (state)
      S_IDLE: begin
        if (|req) begin
          src_d     = winner;
          rr_last_d = winner;
          payload_d = win_data;
          len_d     = win_len;
          ack_d     = 3'b001 << winner;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (!tx_wfull) begin
          winc_d      = 1'b1;
          wdata_d     = {HDR_TAG, src, len};
          byte_idx_d  = 2'd0;
          last_byte_d = 1'b0;
          gap_cnt_d   = GAP_LOAD;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == 3'd0) begin
          if (last_byte) begin
            pkt_count_d = pkt_count + 16'd1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_BYTE;
          end
        end else begin
          gap_cnt_d = gap_cnt - 3'd1;
        end
      end
      S_BYTE: begin
        if (!tx_wfull) begin
          winc_d      = 1'b1;
          wdata_d     = cur_byte;
          byte_idx_d  = byte_idx + 2'd1;
          last_byte_d = (byte_idx == len);
          gap_cnt_d   = GAP_LOAD;
          state_d     = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_last   <= 2'd2;
      src       <= 2'd0;
      len       <= 2'd0;
      byte_idx  <= 2'd0;
      payload   <= 32'd0;
      gap_cnt   <= 3'd0;
      last_byte <= 1'b0;
      ack       <= 3'b000;
      busy      <= 1'b0;
      tx_winc   <= 1'b0;
      tx_wdata  <= 8'd0;
      pkt_count <= 16'd0;
    end else begin
      state     <= state_d;
      rr_last   <= rr_last_d;
      src       <= src_d;
      len       <= len_d;
      byte_idx  <= byte_idx_d;
      payload   <= payload_d;
      gap_cnt   <= gap_cnt_d;
      last_byte <= last_byte_d;
      ack       <= ack_d;
      busy      <= busy_d;
      tx_winc   <= winc_d;
      tx_wdata  <= wdata_d;
      pkt_count <= pkt_count_d;
    end
  end

endmodule

// File: doc/tx_packet_arbiter.md
Name: tx_packet_arbiter

Overview:
- Shares the single write port of the host-bound TX FIFO between three requesters: the MCP3008 sampler, the CCD readout pixel stream, and command status replies.
- Grants requesters round-robin and latches each winner's payload.
- Writes each payload to the FIFO as a framed packet: one header byte, then 1-4 payload bytes, least significant byte first.
- Sits between the controller state machine and the TX FIFO write side, on the system clock domain.

Parameters:
- HDR_TAG, 4'hA: upper nibble of every header byte.
- GAP_CYCLES, 1: idle cycles forced after every write so the FIFO full flag can update. Legal range 1-7.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- req  input  3  per-requester packet request. Bit 0 = MCP, bit 1 = CCD, bit 2 = status.
- len_m1  input  6  per-requester payload length minus one, 2 bits each. Requester i uses bits [2i+1:2i].
- data  input  96  per-requester payload, 32 bits each. Requester i uses bits [32i+31:32i].
- ack  output  3  one-cycle pulse to the granted requester; its payload has been latched.
- busy  output  1  high whenever the state is not IDLE.
- tx_wfull  input  1  TX FIFO full flag.
- tx_winc  output  1  TX FIFO write strobe, one cycle per byte.
- tx_wdata  output  8  TX FIFO write data.
- pkt_count  output  16  count of completed packets, wraps.

Behaviour:
- Reset values: ack=0, busy=0, tx_winc=0, tx_wdata=0, pkt_count=0, state=IDLE, rr_last=2 (so requester 0 has top priority first).
- All outputs are registered.
- States:
  - IDLE: if req != 0, select the winner by round-robin starting at index rr_last+1 mod 3. On the same edge:
    - latch data, len_m1 and source id;
    - set ack[winner]=1 for one cycle;
    - set rr_last=winner;
    - go to HDR.
  - HDR: if tx_wfull=0, drive tx_wdata = {HDR_TAG, src[1:0], len_m1[1:0]} with tx_winc=1 for one cycle, clear byte_idx, go to GAP. If tx_wfull=1, hold with tx_winc=0.
  - GAP: count GAP_CYCLES cycles with tx_winc=0.
    - If the header or a non-final byte was just written, go to BYTE.
    - After the final byte, go to IDLE and increment pkt_count.
  - BYTE: if tx_wfull=0, write latched payload byte byte_idx (bits [8*idx+7:8*idx]) with tx_winc=1, increment byte_idx, go to GAP. If tx_wfull=1, hold.
- Write spacing: tx_winc is never high on two consecutive cycles. Minimum spacing is GAP_CYCLES+1 clocks.
- Latency, with no backpressure and GAP_CYCLES=1:
  - req sampled at edge N: ack is high after edge N.
  - Header write is high after edge N+1.
  - Payload byte k is written after edge N+3+2k.
  - busy falls after the last GAP.
- Packet length: a packet is (len_m1+1) payload bytes plus 1 header byte.
- Requester contract:
  - req is sampled only in IDLE. A request dropped before ack is simply not served.
  - A requester must drop req in the cycle it sees ack. If req is still high at the next IDLE it is treated as a new packet.
  - data and len_m1 are don't-care after ack.
- Backpressure: tx_wfull=1 stalls indefinitely in HDR or BYTE with no data loss. The stall resumes on the first cycle tx_wfull=0.
- Simultaneous requests: exactly one ack per arbitration, and losers keep waiting. Under continuous all-request load, grants cycle 0,1,2,0,...
- pkt_count wraps from 16'hFFFF to 0.
- Reset mid-packet: everything returns to reset values immediately. The partial packet is abandoned with no further writes.

Test Plan:
- Single request: reset, then req=3'b001, len_m1[1:0]=3, data[31:0]=32'h44332211 -> ack[0] pulse; writes A3,11,22,33,44 at 2-cycle spacing; pkt_count=1.
- Round-robin: req=3'b111 held (each requester re-raises after its ack); lengths 0, 1, 0 -> grant order 0,1,2,0. Headers are A0, A5, A8, A0.
- Backpressure: tx_wfull=1 during HDR for 10 cycles, then 0 -> no tx_winc while full; header written on the first cycle after release; byte order intact.
- Full toggling every cycle on a 4-byte packet -> all 5 bytes written once each, in order; no winc while full; never two consecutive winc.
- Reset mid-packet: assert rst after the second payload byte -> tx_winc=0 immediately, busy=0, pkt_count unchanged. A new req=3'b100 then gets ack[2] and header A8 (rr_last reset to 2, so the tie order restarts at 0).
